// File: rtl/full_adder_reg.sv
// rtl/full_adder_reg.sv - registered N-bit ripple-carry adder built from 1-bit full-adder cells
//
// Purpose:
//   Computes {Cout,S} = A + B + Cin through a chain of WIDTH full-adder cells.
//   The sum, carry-out and signed overflow are registered, so results appear
//   one clock after the inputs are sampled. WIDTH=1 gives a clocked single-bit
//   full adder.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   A/B/Cin qualify this cycle
//   A, B       in   [WIDTH-1:0] unsigned operands
//   Cin        in   carry into bit 0
//   S          out  [WIDTH-1:0] registered sum
//   Cout       out  registered carry out of the MSB cell
//   ovf        out  registered signed overflow (carry into MSB ^ carry out of MSB)
//   out_valid  out  S/Cout/ovf hold a result captured from a valid input

module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             out_valid
);

  // c[i] is the carry into cell i; c[WIDTH] is the carry out of the MSB cell.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s_comb[i] = A[i] ^ B[i] ^ c[i];
    assign c[i+1]    = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
  end

  // For WIDTH=1 c[WIDTH-1] is Cin, so this reduces to Cin ^ Cout.
  logic ovf_comb;
  assign ovf_comb = c[WIDTH-1] ^ c[WIDTH];

  // Result registers only load on a valid input, so X on idle inputs never
  // reaches the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= s_comb;
        Cout <= c[WIDTH];
        ovf  <= ovf_comb;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_reg.sv
// tb/tb_full_adder_reg.sv - directed self-checking bench for full_adder_reg (WIDTH=1 and WIDTH=8)

module tb_full_adder_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=1 instance
  logic v1, a1, b1, c1;
  logic s1, co1, ovf1, ov1;

  // WIDTH=8 instance
  logic       v8, c8;
  logic [7:0] a8, b8;
  logic [7:0] s8;
  logic       co8, ovf8, ov8;

  full_adder_reg #(.WIDTH(1)) u_fa1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
    .S(s1), .Cout(co1), .ovf(ovf1), .out_valid(ov1)
  );

  full_adder_reg #(.WIDTH(8)) u_fa8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8), .Cin(c8),
    .S(s8), .Cout(co8), .ovf(ovf8), .out_valid(ov8)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_fa [8];
  logic [7:0] m_s;
  logic       m_co, m_ovf, m_ov;
  logic [8:0] sum9;

  initial begin
    exp_fa = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Reset held with valid, all-ones inputs
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b1;
    tick();
    tick();
    chk("rst_s1", s1, 0);
    chk("rst_cout1", co1, 0);
    chk("rst_ovf1", ovf1, 0);
    chk("rst_ov1", ov1, 0);
    chk("rst_s8", s8, 0);
    chk("rst_cout8", co8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_ov8", ov8, 0);

    rst_n = 1'b1;
    tick();
    chk("post_rst_s1", s1, 1);
    chk("post_rst_cout1", co1, 1);
    chk("post_rst_ov1", ov1, 1);
    chk("post_rst_s8", s8, 8'h03);
    v8 = 1'b0;

    // Exhaustive 1-bit truth table
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      tick();
      chk($sformatf("fa1_cs_%0d", i), {co1, s1}, exp_fa[i]);
      chk($sformatf("fa1_ovf_%0d", i), ovf1, c1 ^ exp_fa[i][1]);
      chk($sformatf("fa1_ov_%0d", i), ov1, 1);
    end

    // Hold with in_valid low while inputs toggle or go unknown
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    tick();
    chk("hold_load_s", s1, 0);
    chk("hold_load_cout", co1, 1);
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
      end else begin
        {a1, b1, c1} = 3'(i * 3 + 2);
      end
      tick();
      chk($sformatf("hold_s_%0d", i), s1, 0);
      chk($sformatf("hold_cout_%0d", i), co1, 1);
      chk($sformatf("hold_ov_%0d", i), ov1, 0);
    end

    // Wide carry ripple and signed overflow
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    tick();
    chk("ripple_s", s8, 8'h00);
    chk("ripple_cout", co8, 1);
    chk("ripple_ovf", ovf8, 0);
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    tick();
    chk("ovf_s", s8, 8'h80);
    chk("ovf_cout", co8, 0);
    chk("ovf_ovf", ovf8, 1);

    // Back-to-back valids
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    tick();
    chk("b2b0_s", s8, 8'h46);
    chk("b2b0_cout", co8, 0);
    a8 = 8'hF0; b8 = 8'h10; c8 = 1'b0;
    tick();
    chk("b2b1_s", s8, 8'h00);
    chk("b2b1_cout", co8, 1);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    tick();
    chk("b2b2_s", s8, 8'hFF);
    chk("b2b2_cout", co8, 1);
    chk("b2b2_ovf", ovf8, 0);
    chk("b2b2_ov", ov8, 1);
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    tick();
    chk("zero_s", s8, 8'h00);
    chk("zero_cout", co8, 0);

    // Random stream with periodic resets against a reference model
    m_s = 8'h00; m_co = 1'b0; m_ovf = 1'b0; m_ov = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      rst_n = !((k % 97) == 50 || (k % 97) == 51);
      v8 = 1'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      if (!rst_n) begin
        m_s = 8'h00; m_co = 1'b0; m_ovf = 1'b0; m_ov = 1'b0;
      end else if (v8) begin
        sum9  = {1'b0, a8} + {1'b0, b8} + {8'h00, c8};
        m_s   = sum9[7:0];
        m_co  = sum9[8];
        m_ovf = (a8[7] == b8[7]) && (sum9[7] != a8[7]);
        m_ov  = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
      tick();
      chk($sformatf("rnd_s_%0d", k), s8, m_s);
      chk($sformatf("rnd_cout_%0d", k), co8, m_co);
      chk($sformatf("rnd_ovf_%0d", k), ovf8, m_ovf);
      chk($sformatf("rnd_ov_%0d", k), ov8, m_ov);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
- Registered N-bit ripple-carry adder built from 1-bit full-adder cells: S = A + B + Cin, with carry-out Cout.
- Default WIDTH=1 gives a clocked single-bit full adder; wider instances are used as the adder primitive in datapaths.
- Outputs are registered with a 1-cycle latency and carry a valid flag, so the block can drop into pipelined logic.

Parameters:
- WIDTH, 1, operand/sum bit width (>=1).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  A/B/Cin qualify this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry-in to bit 0.
- S  output  WIDTH  registered sum, bits [WIDTH-1:0].
- Cout  output  1  registered carry-out of the MSB cell.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  S/Cout/ovf hold a result captured from a valid input.

Behaviour:
- Cell equations, bit i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - c[0] = Cin; Cout = c[WIDTH].
- Arithmetic identity: {Cout,S} = A + B + Cin, computed exactly at WIDTH+1 bits with no truncation beyond that.
- ovf = c[WIDTH-1] ^ c[WIDTH]. For WIDTH=1 this is Cin ^ Cout.
- Reset, when rst_n=0 at a rising clk edge:
  - S=0, Cout=0, ovf=0, out_valid=0.
  - Reset overrides in_valid in the same cycle.
  - Reset mid-stream discards the pending result.
- Normal operation, rst_n=1 at the edge:
  - in_valid=1: S, Cout, ovf load the combinational result of the current A, B, Cin; out_valid <= 1.
  - in_valid=0: S, Cout, ovf hold their previous values; out_valid <= 0.
- Latency and throughput:
  - Latency is exactly 1 clock from sampled inputs to outputs.
  - Throughput is one result per cycle, with back-to-back valids allowed.
  - No backpressure: there is no ready signal and the consumer must accept every out_valid.
- Outputs change only on rising clk edges. No combinational path from inputs to outputs.
- Boundary cases:
  - All-ones A and B with Cin=1 gives S = all-ones and Cout=1.
  - All zeros gives S=0 and Cout=0.
  - Carry ripples through all WIDTH cells within one cycle.
- X on A/B/Cin while in_valid=0 must not affect the outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=1, B=1, Cin=1 -> S=0, Cout=0, ovf=0, out_valid=0. Release reset -> the next edge yields S=1, Cout=1.
- Exhaustive 1-bit (WIDTH=1): apply {A,B,Cin} = 000, 001, 010, 011, 100, 101, 110, 111, one per cycle with in_valid=1. One cycle later, {Cout,S} must be 00, 01, 01, 10, 01, 10, 10, 11; out_valid=1 throughout.
- Hold: after A=1, B=0, Cin=1 (S=0, Cout=1), drive in_valid=0 and toggle the inputs -> S/Cout stay 0/1 and out_valid=0.
- Wide carry ripple (WIDTH=8): A=8'hFF, B=8'h00, Cin=1 -> S=8'h00, Cout=1, ovf=0. Then A=8'h7F, B=8'h01, Cin=0 -> S=8'h80, Cout=0, ovf=1.
- Back-to-back (WIDTH=8): 3 consecutive valids (8'h12+8'h34+0, 8'hF0+8'h10+0, 8'hFF+8'hFF+1) -> S/Cout = 8'h46/0, 8'h00/1, 8'hFF/1 on consecutive cycles.
- Random (WIDTH=8): 1000 random A/B/Cin/in_valid with periodic mid-stream resets -> the registered output matches the reference model A+B+Cin delayed 1 cycle, and outputs clear on every reset.
